// File: rtl/key_codes_pkg.sv
// Shared definitions for the keypad time-entry path.
// Holds the command key codes, the one-hot FSM state encoding and the BCD
// limits used when validating an HHMMSS value.
package key_codes_pkg;

    // Command key codes; 0-9 are digits, 14-15 carry no meaning.
    localparam logic [3:0] KEY_SET    = 4'd10;
    localparam logic [3:0] KEY_BKSP   = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;
    localparam logic [3:0] KEY_ENTER  = 4'd13;
    localparam logic [3:0] DIGIT_MAX  = 4'd9;

    localparam int NUM_DIGITS = 6;

    // BCD limits for a 24-hour HHMMSS value
    localparam logic [3:0] HT_MAX        = 4'd2;  // hours tens
    localparam logic [3:0] HU_MAX_AT_HT2 = 4'd3;  // hours units when tens is 2
    localparam logic [3:0] MS_TENS_MAX   = 4'd5;  // minutes/seconds tens
    localparam logic [3:0] UNIT_MAX      = 4'd9;  // any units nibble

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ENTRY = 4'b0010,
        ST_CHECK = 4'b0100,
        ST_WRITE = 4'b1000
    } state_t;

endpackage

// File: rtl/bcd_time_check.sv
// Combinational validity check of a 24-bit BCD time {Ht,Hu,Mt,Mu,St,Su}.
// Ports:
//   bcd_time - time to check, hours tens in bits 23:20
//   valid    - 1 when the value is a legal 00:00:00..23:59:59 time
module bcd_time_check
    import key_codes_pkg::*;
(
    input  logic [23:0] bcd_time,
    output logic        valid
);

    logic [3:0] ht, hu, mt, mu, st, su;

    assign ht = bcd_time[23:20];
    assign hu = bcd_time[19:16];
    assign mt = bcd_time[15:12];
    assign mu = bcd_time[11:8];
    assign st = bcd_time[7:4];
    assign su = bcd_time[3:0];

    assign valid = (ht <= HT_MAX)
                 && !((ht == HT_MAX) && (hu > HU_MAX_AT_HT2))
                 && (mt <= MS_TENS_MAX)
                 && (st <= MS_TENS_MAX)
                 && (hu <= UNIT_MAX)
                 && (mu <= UNIT_MAX)
                 && (su <= UNIT_MAX);

endmodule

// File: rtl/key_time_entry.sv
// Keypad-driven HHMMSS time entry with validation and RTC write handshake.
// Ports:
//   CLK, nRST     - clock, asynchronous active-low reset
//   KEY_Value     - key code from the keypad scanner
//   Value_en      - key valid; each rising edge is one key event
//   entry_active  - high while a time is being entered or checked
//   digit_cnt     - number of digits entered (0..6)
//   edit_bcd      - live edit buffer, unentered nibbles read as 0
//   time_bcd      - last committed valid time
//   wr_req/wr_ack - write handshake towards the RTC controller
//   done          - 1-cycle pulse on an acknowledged write
//   err           - 1-cycle pulse on a rejected key, bad time or timeout
module key_time_entry
    import key_codes_pkg::*;
#(
    parameter int ENTRY_TIMEOUT = 500000000,
    parameter int ACK_TIMEOUT   = 1000,
    parameter int CNT_W         = 29
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [3:0]  KEY_Value,
    input  logic        Value_en,
    output logic        entry_active,
    output logic [2:0]  digit_cnt,
    output logic [23:0] edit_bcd,
    output logic [23:0] time_bcd,
    output logic        wr_req,
    input  logic        wr_ack,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]       FULL_CNT   = 3'(NUM_DIGITS);

    state_t           state_reg, state_next;
    logic             value_en_d_reg, key_evt_reg;
    logic [3:0]       key_code_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [23:0]      edit_reg, edit_next;
    logic [23:0]      time_reg, time_next;
    logic [2:0]       dcnt_reg, dcnt_next;
    logic             wr_req_reg, wr_req_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             active_reg, active_next;
    logic [23:0]      wr_mask, clr_mask;
    logic             key_hit, time_ok;

    bcd_time_check u_check (
        .bcd_time (edit_reg),
        .valid    (time_ok)
    );

    // wr_mask selects the nibble the next digit lands in; clr_mask selects
    // the most recently entered nibble (the one a backspace removes).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign wr_mask[23-4*gi -: 4]  = (dcnt_reg == 3'(gi))     ? 4'hF : 4'h0;
            assign clr_mask[23-4*gi -: 4] = (dcnt_reg == 3'(gi + 1)) ? 4'hF : 4'h0;
        end
    endgenerate

    // Codes 14-15 are not events at all, so they do not refresh the timeout.
    assign key_hit = key_evt_reg && (key_code_reg <= KEY_ENTER);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            value_en_d_reg <= 1'b0;
            key_evt_reg    <= 1'b0;
            key_code_reg   <= 4'd0;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            edit_reg       <= '0;
            time_reg       <= '0;
            dcnt_reg       <= '0;
            wr_req_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            active_reg     <= 1'b0;
        end else begin
            value_en_d_reg <= Value_en;
            key_evt_reg    <= Value_en && !value_en_d_reg;
            key_code_reg   <= KEY_Value;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            edit_reg       <= edit_next;
            time_reg       <= time_next;
            dcnt_reg       <= dcnt_next;
            wr_req_reg     <= wr_req_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
            active_reg     <= active_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        edit_next   = edit_reg;
        dcnt_next   = dcnt_reg;
        time_next   = time_reg;
        wr_req_next = wr_req_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (key_hit && (key_code_reg == KEY_SET)) begin
                    state_next = ST_ENTRY;
                    edit_next  = '0;
                    dcnt_next  = '0;
                end
            end

            ST_ENTRY: begin
                // A key arriving on the expiry cycle wins over the timeout.
                if (key_hit) begin
                    cnt_next = '0;
                    if (key_code_reg <= DIGIT_MAX) begin
                        if (dcnt_reg < FULL_CNT) begin
                            edit_next = (edit_reg & ~wr_mask)
                                      | ({NUM_DIGITS{key_code_reg}} & wr_mask);
                            dcnt_next = dcnt_reg + 3'd1;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else begin
                        case (key_code_reg)
                            KEY_BKSP: begin
                                if (dcnt_reg != 3'd0) begin
                                    edit_next = edit_reg & ~clr_mask;
                                    dcnt_next = dcnt_reg - 3'd1;
                                end else begin
                                    err_next = 1'b1;
                                end
                            end
                            KEY_CANCEL: begin
                                state_next = ST_IDLE;
                                edit_next  = '0;
                                dcnt_next  = '0;
                            end
                            KEY_SET: begin
                                edit_next = '0;
                                dcnt_next = '0;
                            end
                            KEY_ENTER: begin
                                if (dcnt_reg == FULL_CNT) begin
                                    state_next = ST_CHECK;
                                end else begin
                                    err_next = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (cnt_reg == ENTRY_LAST) begin
                    state_next = ST_IDLE;
                    edit_next  = '0;
                    dcnt_next  = '0;
                    cnt_next   = '0;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            ST_CHECK: begin
                cnt_next = '0;
                if (time_ok) begin
                    time_next   = edit_reg;
                    wr_req_next = 1'b1;
                    state_next  = ST_WRITE;
                end else begin
                    err_next   = 1'b1;
                    state_next = ST_ENTRY;
                    edit_next  = '0;
                    dcnt_next  = '0;
                end
            end

            ST_WRITE: begin
                if (wr_ack) begin
                    wr_req_next = 1'b0;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                    edit_next   = '0;
                    dcnt_next   = '0;
                    cnt_next    = '0;
                end else if (cnt_reg == ACK_LAST) begin
                    // time_bcd deliberately keeps the unacknowledged value.
                    wr_req_next = 1'b0;
                    err_next    = 1'b1;
                    state_next  = ST_IDLE;
                    edit_next   = '0;
                    dcnt_next   = '0;
                    cnt_next    = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next  = ST_IDLE;
                wr_req_next = 1'b0;
                cnt_next    = '0;
            end
        endcase

        active_next = (state_next == ST_ENTRY) || (state_next == ST_CHECK);
    end

    assign entry_active = active_reg;
    assign digit_cnt    = dcnt_reg;
    assign edit_bcd     = edit_reg;
    assign time_bcd     = time_reg;
    assign wr_req       = wr_req_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_key_time_entry.sv
// Scoreboard bench for key_time_entry: the stimulus side feeds keys into a
// digit-list reference model and queues the expected output snapshot for the
// cycle it must appear in; a monitor pops and compares on the falling edge.
module tb_key_time_entry;
    import key_codes_pkg::*;

    localparam int ENTRY_TO = 100;
    localparam int ACK_TO   = 1000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  KEY_Value;
    logic        Value_en;
    logic        wr_ack;
    logic        entry_active;
    logic [2:0]  digit_cnt;
    logic [23:0] edit_bcd;
    logic [23:0] time_bcd;
    logic        wr_req;
    logic        done;
    logic        err;

    key_time_entry #(
        .ENTRY_TIMEOUT (ENTRY_TO),
        .ACK_TIMEOUT   (ACK_TO),
        .CNT_W         (29)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .KEY_Value    (KEY_Value),
        .Value_en     (Value_en),
        .entry_active (entry_active),
        .digit_cnt    (digit_cnt),
        .edit_bcd     (edit_bcd),
        .time_bcd     (time_bcd),
        .wr_req       (wr_req),
        .wr_ack       (wr_ack),
        .done         (done),
        .err          (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_edit;
        logic [23:0] edit;
        logic [2:0]  cnt;
        logic        active;
        logic        req;
        logic        e;
        logic        d;
        logic [23:0] tm;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0, done_seen = 0, both_seen = 0;
    int   err_exp = 0, done_exp = 0;

    // Reference model: the entry as a list of decimal digits plus a mode.
    int          digs[$];
    int          m_mode = 0;   // 0 idle, 1 entry, 2 check, 3 write
    logic [23:0] m_time = 24'd0;
    int          m_last = 0;   // cycle of the last event seen in entry
    int          last_c = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [23:0] m_edit();
        logic [23:0] v;
        v = 24'd0;
        foreach (digs[i]) v = v | (24'(digs[i]) << (20 - 4 * i));
        return v;
    endfunction

    function automatic bit m_valid();
        int hh, mm, ss;
        hh = digs[0] * 10 + digs[1];
        mm = digs[2] * 10 + digs[3];
        ss = digs[4] * 10 + digs[5];
        return (hh <= 23) && (mm <= 59) && (ss <= 59);
    endfunction

    function automatic void push(input int c, input string nm, input bit chk_edit,
                                 input logic req, input logic e, input logic d);
        exp_t x;
        x.cyc      = c;
        x.name     = nm;
        x.chk_edit = chk_edit;
        x.edit     = m_edit();
        x.cnt      = 3'(digs.size());
        x.active   = (m_mode == 1) || (m_mode == 2);
        x.req      = req;
        x.e        = e;
        x.d        = d;
        x.tm       = m_time;
        exp_q.push_back(x);
    endfunction

    // Applies one key event (raised after posedge c) to the model.
    task automatic model_key(input logic [3:0] k, input int c, output bit commit);
        bit e;
        commit = 1'b0;
        e = 1'b0;
        if (m_mode == 0) begin
            if (k == KEY_SET) begin
                m_mode = 1;
                digs.delete();
                m_last = c + 2;
            end
            push(c + 2, $sformatf("idle_key%0d", k), 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (k > KEY_ENTER) begin
            push(c + 2, "ignored_key", 1'b1, 1'b0, 1'b0, 1'b0);
        end else begin
            m_last = c + 2;
            if (k <= 4'd9) begin
                if (digs.size() < 6) digs.push_back(int'(k));
                else e = 1'b1;
                if (e) err_exp++;
                push(c + 2, $sformatf("digit%0d", k), 1'b1, 1'b0, e, 1'b0);
            end else if (k == KEY_BKSP) begin
                if (digs.size() > 0) void'(digs.pop_back());
                else e = 1'b1;
                if (e) err_exp++;
                push(c + 2, "bksp", 1'b1, 1'b0, e, 1'b0);
            end else if (k == KEY_CANCEL) begin
                m_mode = 0;
                digs.delete();
                push(c + 2, "cancel", 1'b1, 1'b0, 1'b0, 1'b0);
            end else if (k == KEY_SET) begin
                digs.delete();
                push(c + 2, "restart", 1'b1, 1'b0, 1'b0, 1'b0);
            end else if (digs.size() < 6) begin
                err_exp++;
                push(c + 2, "enter_short", 1'b1, 1'b0, 1'b1, 1'b0);
            end else begin
                m_mode = 2;
                push(c + 2, "enter_check", 1'b1, 1'b0, 1'b0, 1'b0);
                if (m_valid()) begin
                    m_time = m_edit();
                    m_mode = 3;
                    commit = 1'b1;
                    push(c + 3, "commit", 1'b1, 1'b1, 1'b0, 1'b0);
                end else begin
                    m_mode = 1;
                    digs.delete();
                    m_last = c + 3;
                    err_exp++;
                    push(c + 3, "reject", 1'b1, 1'b0, 1'b1, 1'b0);
                end
            end
        end
    endtask

    // ack_d > 0: ack raised after posedge c+2+ack_d; 0: never ack; <0: caller handles.
    task automatic send_key(input logic [3:0] k, input int hold = 1,
                            input int gap = 2, input int ack_d = 4);
        int c;
        bit commit;
        @(posedge CLK);
        #1;
        c = cyc;
        KEY_Value = k;
        Value_en  = 1'b1;
        model_key(k, c, commit);
        last_c = c;
        repeat (hold) @(posedge CLK);
        #1 Value_en = 1'b0;
        if (commit && ack_d > 0) begin
            while (cyc < c + 2 + ack_d) @(posedge CLK);
            #1;
            wr_ack = 1'b1;
            push(c + 2 + ack_d, "req_hold", 1'b1, 1'b1, 1'b0, 1'b0);
            m_mode = 0;
            digs.delete();
            done_exp++;
            push(c + 3 + ack_d, "write_done", 1'b1, 1'b0, 1'b0, 1'b1);
            @(posedge CLK);
            #1 wr_ack = 1'b0;
        end else if (commit && ack_d == 0) begin
            push(c + 2 + ACK_TO, "req_last", 1'b1, 1'b1, 1'b0, 1'b0);
            m_mode = 0;
            digs.delete();
            err_exp++;
            push(c + 3 + ACK_TO, "ack_timeout", 1'b0, 1'b0, 1'b1, 1'b0);
            while (cyc < c + 4 + ACK_TO) @(posedge CLK);
        end
        repeat (gap) @(posedge CLK);
    endtask

    task automatic entry_timeout();
        push(m_last + ENTRY_TO - 1, "to_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        m_mode = 0;
        digs.delete();
        err_exp++;
        push(m_last + ENTRY_TO, "entry_timeout", 1'b1, 1'b0, 1'b1, 1'b0);
        while (cyc < m_last + ENTRY_TO + 2) @(posedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " entry_active"}, 64'(entry_active), 64'(0));
        check({tag, " digit_cnt"},    64'(digit_cnt),    64'(0));
        check({tag, " edit_bcd"},     64'(edit_bcd),     64'(0));
        check({tag, " time_bcd"},     64'(time_bcd),     64'(0));
        check({tag, " wr_req"},       64'(wr_req),       64'(0));
        check({tag, " done"},         64'(done),         64'(0));
        check({tag, " err"},          64'(err),          64'(0));
    endtask

    task automatic send_seq(input logic [3:0] ks[], input int ack_d = 4);
        foreach (ks[i]) send_key(ks[i], 1, 2, ack_d);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // Monitor: compares queued expectations and tallies output pulses.
    initial begin
        exp_t x;
        forever begin
            @(negedge CLK);
            if (err) err_seen++;
            if (done) done_seen++;
            if (err && done) both_seen++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                x = exp_q.pop_front();
                check({x.name, " cycle"}, 64'(cyc), 64'(x.cyc));
                if (x.chk_edit) begin
                    check({x.name, " edit_bcd"},  64'(edit_bcd),  64'(x.edit));
                    check({x.name, " digit_cnt"}, 64'(digit_cnt), 64'(x.cnt));
                end
                check({x.name, " entry_active"}, 64'(entry_active), 64'(x.active));
                check({x.name, " wr_req"},       64'(wr_req),       64'(x.req));
                check({x.name, " err"},          64'(err),          64'(x.e));
                check({x.name, " done"},         64'(done),         64'(x.d));
                check({x.name, " time_bcd"},     64'(time_bcd),     64'(x.tm));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] k;
        int r;
        nRST      = 1'b0;
        KEY_Value = 4'd0;
        Value_en  = 1'b0;
        wr_ack    = 1'b0;
        repeat (3) @(posedge CLK);
        #2 check_reset_outputs("reset");
        @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (2) @(posedge CLK);

        // Valid commit, ack three cycles after wr_req appears
        send_seq('{KEY_SET, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, KEY_ENTER}, 4);

        // 24:00:00 is rejected
        send_seq('{KEY_SET, 4'd2, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, KEY_ENTER, KEY_CANCEL});

        // Backspace then cancel
        send_seq('{KEY_SET, 4'd1, 4'd2, KEY_BKSP, 4'd7, KEY_CANCEL});

        // Short ENTER, then overflow with seven digits
        send_seq('{KEY_SET, 4'd1, 4'd2, 4'd3, KEY_ENTER, KEY_BKSP, KEY_BKSP, KEY_BKSP, KEY_BKSP});
        send_seq('{KEY_SET, 4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 4'd1, KEY_CANCEL});

        // Commit without ack, then an abandoned entry
        send_seq('{KEY_SET, 4'd0, 4'd9, 4'd3, 4'd0, 4'd0, 4'd0, KEY_ENTER}, 0);
        send_seq('{KEY_SET, 4'd5});
        entry_timeout();

        // Held Value_en counts once
        send_key(KEY_SET);
        send_key(4'd0, 5, 2);
        send_seq('{4'd8, 4'd1, 4'd5, 4'd3, 4'd0});
        send_key(KEY_ENTER, 1, 0, -1);
        while (cyc < last_c + 5) @(posedge CLK);
        #2 nRST = 1'b0;
        #1 check_reset_outputs("reset_in_write");
        m_mode = 0;
        digs.delete();
        m_time = 24'd0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        repeat (2) @(posedge CLK);

        // Randomized key stream
        for (int n = 0; n < 160; n++) begin
            r = $urandom_range(0, 99);
            if (m_mode == 0) k = (r < 50) ? KEY_SET : 4'($urandom_range(0, 15));
            else if (r < 70) k = 4'($urandom_range(0, 9));
            else k = 4'($urandom_range(10, 15));
            send_key(k, $urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 6));
        end
        if (m_mode == 1) send_key(KEY_CANCEL);

        repeat (5) @(posedge CLK);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("err_pulses",    64'(err_seen),     64'(err_exp));
        check("done_pulses",   64'(done_seen),    64'(done_exp));
        check("err_done_overlap", 64'(both_seen), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_time_entry.md
Name: key_time_entry

Overview:
Consumes decoded keypad events (4-bit key code plus valid strobe from the matrix keypad scanner) and assembles a 6-digit BCD time HHMMSS entered by the user. It validates the entry, then hands the committed time to the DS1302 controller through a req/ack write handshake. It sits between the keypad scanner and the RTC write path and also drives the live-edit buffer to the display.

Parameters:
ENTRY_TIMEOUT, 500000000, cycles without a key event in ENTRY before abandoning the entry (10 s at 50 MHz).
ACK_TIMEOUT, 1000, cycles wr_req may wait for wr_ack before the write is abandoned.
CNT_W, 29, width of the shared timeout counter; must hold max(ENTRY_TIMEOUT, ACK_TIMEOUT).

Ports:
CLK  input  1  system clock
nRST  input  1  reset, asynchronous, active-low
KEY_Value  input  4  key code from the keypad scanner
Value_en  input  1  key code valid; a rising edge is one key event
entry_active  output  1  high in ENTRY and CHECK
digit_cnt  output  3  digits currently entered, 0..6
edit_bcd  output  24  live buffer {Ht,Hu,Mt,Mu,St,Su}, unentered nibbles 0
time_bcd  output  24  last committed valid time
wr_req  output  1  write request to the RTC controller
wr_ack  input  1  RTC controller accepted time_bcd
done  output  1  1-cycle pulse on successful write
err  output  1  1-cycle pulse on any rejected action or timeout

Behaviour:
- Reset (async, nRST=0): state=IDLE; entry_active=0, digit_cnt=0, edit_bcd=0, time_bcd=0, wr_req=0, done=0, err=0; edge register=0; timeout counter=0. Reset during WRITE drops wr_req immediately.
- Key event: Value_en=1 while the previous-cycle Value_en=0. It is registered, so the FSM acts one cycle after the edge. A Value_en that is held high counts once.
- Key codes: 0-9 digit; 10 SET; 11 BACKSPACE; 12 CANCEL; 13 ENTER; 14-15 ignored in every state.
- IDLE: only SET has an effect. SET goes to ENTRY, clears edit_bcd and digit_cnt, and clears the counter.
- ENTRY, any key event clears the timeout counter. Per key:
  - Digit with digit_cnt<6: write the nibble at index digit_cnt (index 0 = bits 23:20), then digit_cnt+1.
  - Digit with digit_cnt=6: ignored, err pulse.
  - BACKSPACE with digit_cnt>0: digit_cnt-1 and that nibble cleared to 0.
  - BACKSPACE with digit_cnt=0: err pulse, no change.
  - CANCEL: go to IDLE; edit_bcd and digit_cnt cleared.
  - SET: restart the entry (clear buffer and count, stay in ENTRY).
  - ENTER with digit_cnt=6: go to CHECK.
  - ENTER with digit_cnt<6: err pulse, stay in ENTRY.
  - Timeout: counter reaches ENTRY_TIMEOUT-1 with no event → IDLE, buffer cleared, err pulse.
- CHECK (exactly 1 cycle, keys ignored). Valid iff all of:
  - Ht≤2, and Hu≤3 when Ht=2;
  - Mt≤5 and St≤5;
  - every units nibble ≤9.
  - Valid: time_bcd←edit_bcd, wr_req←1, counter cleared, go to WRITE.
  - Invalid: err pulse, return to ENTRY with edit_bcd and digit_cnt cleared.
- WRITE (keys ignored, entry_active=0): wr_req stays high until the first cycle with wr_ack=1.
  - That cycle: wr_req←0, done pulse, go to IDLE, edit_bcd and digit_cnt cleared.
  - Counter reaching ACK_TIMEOUT-1 first: wr_req←0, err pulse, go to IDLE. time_bcd keeps the unacknowledged value.
  - wr_ack while wr_req=0 is ignored.
- Output registering: all outputs are registered. done and err are never high in the same cycle, and each is exactly 1 cycle wide.
- Key event on the same cycle as a timeout expiry: the key wins and the counter is cleared.

Decomposition:
- Shared package key_codes_pkg: KEY_SET=10, KEY_BKSP=11, KEY_CANCEL=12, KEY_ENTER=13; the FSM state encoding (one-hot: IDLE, ENTRY, CHECK, WRITE); BCD limit constants.
- One sub-module, bcd_time_check: combinational 24-bit HHMMSS validity check, reusable by the RTC readback path.

Test Plan:
- Key sequence SET,1,2,3,4,5,6,ENTER, with wr_ack 3 cycles after wr_req → edit_bcd steps to 0x123456; time_bcd=0x123456; wr_req high exactly until ack; done pulse; IDLE.
- Key sequence SET,2,4,0,0,0,0,ENTER → err pulse; back in ENTRY with digit_cnt=0; wr_req never asserts; time_bcd unchanged.
- Key sequence SET,1,2,BKSP,7,CANCEL → edit_bcd goes 0x100000, 0x120000, 0x100000, 0x170000, then 0 in IDLE; no err.
- Key sequence SET,1,2,3,ENTER → err pulse; digit_cnt=3 retained. Then 7 digits → the 7th raises err and digit_cnt stays 6.
- Valid commit with wr_ack never asserted → wr_req drops after ACK_TIMEOUT cycles, err pulse; entry timeout (ENTRY_TIMEOUT overridden to 100) → IDLE with err.
- Value_en held high 5 cycles → one digit only; nRST pulsed low during WRITE → wr_req=0 immediately and all outputs at reset values.
